bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-port shared-memory arbiter: fetch (IF) and data (MEM) sides share one bus,
// one outstanding transaction, alternating priority, wait-state timeout abort.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        err_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_M = 2'd1,
    BUSY_I = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_mem_q, last_mem_d;
  logic          if_done_q, if_done_d;
  logic          mem_done_q, mem_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [DW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic          err_q, err_d;
  logic          if_elig, mem_elig, grant_mem;

  // A port that just completed sits out one cycle so a held ce cannot replay a store.
  assign if_elig   = if_ce_i & ~if_done_q;
  assign mem_elig  = mem_ce_i & ~mem_done_q;
  assign grant_mem = mem_elig & ~(if_elig & last_mem_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_mem_d  = last_mem_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d     = BUSY_M;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
        end else if (if_elig) begin
          state_d     = BUSY_I;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
        end
      end
      BUSY_M, BUSY_I: begin
        if (bus_ack_i || cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          last_mem_d = (state_q == BUSY_M);
          err_d      = ~bus_ack_i;
          if (state_q == BUSY_M) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = bus_ack_i ? bus_rdata_i : '0;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = bus_ack_i ? bus_rdata_i : '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_mem_q  <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_mem_q  <= last_mem_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata_o     = if_rdata_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign if_stallreq_o  = if_ce_i & ~if_done_q;
  assign mem_stallreq_o = mem_ce_i & ~mem_done_q;
  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_we_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign err_o          = err_q;

endmodule
